// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter and its response FIFO.
package mult_arbiter_pkg;

    localparam int MUL_W_IN  = 8;
    localparam int MUL_W_OUT = 16;
    localparam int ID_W_MAX  = 3;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [ID_W_MAX-1:0]         id;
        logic signed [MUL_W_OUT-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/mult_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is visible whenever the FIFO is not empty.
module mult_rsp_fifo
    import mult_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       areset_n,
    input  logic                       push,
    input  rsp_entry_t                 push_entry,
    input  logic                       pop,
    output rsp_entry_t                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rsp_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W:0]      count_reg;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Gated so an empty FIFO never exposes stale or uninitialised storage.
    assign head = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!areset_n) !(push && full));

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among N requesters,
// with id-tagged results returned through a credit-protected response FIFO.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N           = 4,
    parameter int MUL_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic [N-1:0]                  req_valid,
    output logic [N-1:0]                  req_ready,
    input  logic [MUL_W_IN*N-1:0]         req_a,
    input  logic [MUL_W_IN*N-1:0]         req_b,
    output logic [MUL_W_IN-1:0]           mul_dataa,
    output logic [MUL_W_IN-1:0]           mul_datab,
    input  logic [MUL_W_OUT-1:0]          mul_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(N)-1:0]        rsp_id,
    output logic [MUL_W_OUT-1:0]          rsp_data
);

    localparam int ID_W  = id_width(N);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ID_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]  inflight_reg;
    logic [CNT_W-1:0]  inflight_next;
    logic              tag_valid_reg [MUL_LATENCY];
    logic [ID_W-1:0]   tag_id_reg    [MUL_LATENCY];

    logic              can_issue;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_idx;
    logic              retire;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              empty;
    logic              unused_fifo_full;
    rsp_entry_t        push_entry;
    rsp_entry_t        head_entry;

    // Credit counts results already queued plus those still in the multiplier,
    // so a retiring result always finds room. areset_n gates grants while reset is held.
    assign can_issue = areset_n &&
        (({1'b0, inflight_reg} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (can_issue) begin
            for (int k = 1; k <= N; k++) begin
                cand = (int'(rr_ptr_reg) + k) % N;
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_W'(cand);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mul_dataa = '0;
        mul_datab = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
            mul_dataa = req_a[grant_idx*MUL_W_IN +: MUL_W_IN];
            mul_datab = req_b[grant_idx*MUL_W_IN +: MUL_W_IN];
        end
    end

    assign retire = tag_valid_reg[MUL_LATENCY-1];

    always_comb begin
        inflight_next = inflight_reg;
        case ({grant_valid, retire})
            2'b10:   inflight_next = inflight_reg + CNT_W'(1);
            2'b01:   inflight_next = inflight_reg - CNT_W'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr_reg       <= ID_W'(N-1);
            inflight_reg     <= '0;
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else begin
            if (grant_valid) begin
                rr_ptr_reg <= grant_idx;
            end
            inflight_reg     <= inflight_next;
            tag_valid_reg[0] <= grant_valid;
            tag_id_reg[0]    <= grant_idx;
        end
    end

    // Tag stages shift unconditionally, matching the non-stallable multiplier.
    generate
        for (genvar gi = 1; gi < MUL_LATENCY; gi++) begin : g_tag_stage
            always_ff @(posedge clk or negedge areset_n) begin
                if (!areset_n) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        push_entry      = '0;
        push_entry.id   = ID_W_MAX'(tag_id_reg[MUL_LATENCY-1]);
        push_entry.data = mul_out;
    end

    assign pop = rsp_valid && rsp_ready;

    mult_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .areset_n   (areset_n),
        .push       (retire),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head_entry),
        .count      (fifo_count),
        .full       (unused_fifo_full),
        .empty      (empty)
    );

    assign rsp_valid = !empty;
    assign rsp_id    = head_entry.id[ID_W-1:0];
    assign rsp_data  = head_entry.data;

    generate
        if (ID_W < ID_W_MAX) begin : g_id_hi
            logic unused_id_hi;
            assign unused_id_hi = ^head_entry.id[ID_W_MAX-1:ID_W];
        end
    endgenerate

endmodule
